// File: rtl/dff_vector_checker.sv
// Stimulus-and-check engine for a register path: drives a count sequence on d_o, compares q_i
// against the expected value LATENCY+1 edges later, and reports pass/fail with first-error capture.
module dff_vector_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned LATENCY     = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic [WIDTH-1:0] d_o,
    input  logic [WIDTH-1:0] q_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [7:0]       err_count_o,
    output logic [9:0]       first_err_idx_o,
    output logic [WIDTH-1:0] first_err_q_o
);

    localparam logic [9:0] LastVec = 10'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {StIdle, StDrive, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [9:0]       vec_q, vec_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [7:0]       err_q, err_d;
    logic [9:0]       fidx_q, fidx_d;
    logic [WIDTH-1:0] fq_q, fq_d;

    // Expected pipeline; stage LATENCY is the tail compared against q_i.
    logic [WIDTH-1:0] exp_q [LATENCY+1];
    logic [9:0]       idx_q [LATENCY+1];
    logic [LATENCY:0] vld_q;

    logic             in_vld;
    logic [WIDTH-1:0] in_exp;
    logic [9:0]       in_idx;
    logic             clear;
    logic             mismatch;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        d_d     = d_q;
        in_vld  = 1'b0;
        in_exp  = '0;
        in_idx  = '0;
        clear   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StDrive;
                    vec_d   = '0;
                    d_d     = '0;
                    in_vld  = 1'b1;
                    clear   = 1'b1;
                end
            end
            StDrive: begin
                if (vec_q == LastVec) begin
                    state_d = StDrain;
                    d_d     = '0;
                end else begin
                    vec_d  = vec_q + 10'd1;
                    d_d    = WIDTH'(vec_d);
                    in_vld = 1'b1;
                    in_exp = d_d;
                    in_idx = vec_d;
                end
            end
            StDrain: begin
                // Only the tail may still be valid: it retires on this same edge.
                if (vld_q[LATENCY-1:0] == '0) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mismatch = vld_q[LATENCY] && (q_i != exp_q[LATENCY]);

    always_comb begin
        err_d  = err_q;
        fidx_d = fidx_q;
        fq_d   = fq_q;
        if (clear) begin
            err_d  = '0;
            fidx_d = '0;
            fq_d   = '0;
        end else if (mismatch) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            if (err_q == 8'h00) begin
                fidx_d = idx_q[LATENCY];
                fq_d   = q_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            vec_q   <= '0;
            d_q     <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fq_q    <= '0;
            vld_q   <= '0;
            for (int unsigned i = 0; i <= LATENCY; i++) begin
                exp_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            d_q      <= d_d;
            err_q    <= err_d;
            fidx_q   <= fidx_d;
            fq_q     <= fq_d;
            vld_q    <= {vld_q[LATENCY-1:0], in_vld};
            exp_q[0] <= in_exp;
            idx_q[0] <= in_idx;
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                exp_q[i] <= exp_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign d_o             = d_q;
    assign busy_o          = (state_q == StDrive) || (state_q == StDrain);
    assign done_o          = (state_q == StDone);
    assign pass_o          = (state_q == StDone) && (err_q == 8'h00);
    assign err_count_o     = err_q;
    assign first_err_idx_o = fidx_q;
    assign first_err_q_o   = fq_q;

endmodule

// File: doc/dff_vector_checker.md
# dff_vector_checker

Synthesizable stimulus-and-check engine for the 4-bit D flip-flop register path. It drives the register's `d` input with a deterministic count sequence and samples its `q` output. It compares each sample against the expected value after a configurable latency, then reports pass/fail, an error count and the first failing vector. It sits on the tester side of the `d`/`q` interface, in place of the program-block bench, so the register can be self-checked on silicon or in emulation.

## Interface
- `WIDTH`, 4: data width of `d`/`q`.
- `NUM_VECTORS`, 16: vectors issued per run, range 1..1023.
- `LATENCY`, 1: clock edges from the edge that captures `d` to `q` showing it, range 1..4.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: run request, sampled only in IDLE and DONE.
- `d` output WIDTH: registered stimulus to the DUT.
- `q` input WIDTH: DUT response.
- `busy` output 1: high in DRIVE and DRAIN.
- `done` output 1: high in DONE.
- `pass` output 1: valid when `done`; 1 iff `err_count`==0.
- `err_count` output 8: mismatches in the current/last run, saturating at 255.
- `first_err_idx` output 10: index of the first mismatching vector; valid when `err_count`!=0.
- `first_err_q` output WIDTH: `q` value captured at the first mismatch.

## Operation
- Reset (`reset`=0, immediate):
  - FSM=IDLE.
  - `d`, `err_count`, `first_err_idx`, `first_err_q` = 0.
  - `busy`, `done`, `pass` = 0.
  - Expected pipeline and all valid bits cleared.
- FSM states:
  - IDLE: `start`=1 -> DRIVE. Clears error state and sets `d`=vector 0 on the same edge.
  - DRIVE: issues one vector per cycle. Vector k drives `d` = k mod 2^WIDTH (wraps, e.g. 16 -> 0 for WIDTH=4). After vector NUM_VECTORS-1 has been held for one cycle, goes to DRAIN and `d` returns to 0.
  - DRAIN: waits until all outstanding compares retire, then -> DONE.
  - DONE: holds results. `start`=1 -> DRIVE, clearing counts, with the same behaviour as from IDLE.
- Expected pipeline:
  - A shift register of depth LATENCY+1 carries (expected value, vector index, valid), shifted every cycle.
  - Each issued vector enters with valid=1; the cycles after DRIVE enter with valid=0.
  - The compare is done at the pipeline tail when valid=1.
- Mismatch (`q` != expected):
  - `err_count` increments, saturating at 255 with no wrap.
  - On the first mismatch of the run only, `first_err_idx` and `first_err_q` are loaded.
- `start` in DRIVE or DRAIN is ignored, with no restart and no queuing.
- The compare uses the full WIDTH. The vector index counter is 10 bits.

## Timing
- `start` high at edge N: `d`=vector 0 and `busy`=1 after edge N.
- Vector k is on `d` after edge N+k and is compared against `q` sampled at edge N+k+LATENCY+1.
- `d`=0 after edge N+NUM_VECTORS.
- Last compare at edge N+NUM_VECTORS+LATENCY.
- On that same edge, `busy`=0, `done`=1 and `pass` is final.
- Run length from start edge to `done` high: NUM_VECTORS+LATENCY cycles.
- Reset asserted mid-run aborts at once, giving the reset values above with no partial results kept. After deassertion the block waits in IDLE for `start`.
- A mismatch on the final compare edge is counted before `done` rises, so `pass`=0 in the same cycle.
- The `done`->DRIVE restart clears `err_count` and `pass` on the start edge. The old `first_err_*` values are cleared on that same edge too.

## Test plan
- Ideal DUT: DUT is a 4-bit DFF, WIDTH=4, NUM_VECTORS=16, LATENCY=1, `start` pulsed at edge N.
  - `d` steps 0..15 on edges N..N+15.
  - `done`=1 after edge N+17 with `pass`=1 and `err_count`=0.
  - `busy` is high for exactly 17 cycles.
- Stuck bit: DUT `q[0]` stuck at 0, otherwise as the ideal case.
  - `err_count`=8, `pass`=0.
  - `first_err_idx`=1, `first_err_q`=4'h0.
- Wrap and latency: NUM_VECTORS=20, LATENCY=2, two-stage DUT.
  - Vectors 16..19 drive 0..3, and `pass`=1.
  - `done` comes 22 cycles after start.
  - Repeat with a one-stage DUT: every compare fails, so `err_count`=20.
- Saturation: NUM_VECTORS=300, DUT drives `q`=~d delayed by one.
  - `err_count`=255 (not 44), `first_err_idx`=0, `first_err_q`=4'hF.
- Reset and start handling:
  - Assert `reset` low asynchronously at vector 5. All outputs go to 0 before the next edge, and the FSM is in IDLE.
  - `start` held high during a subsequent DRIVE is ignored and has no effect on counts.
  - `start` in DONE restarts with a cleared `err_count`.
